// File: rtl/bus_ctrl.sv
// bus_ctrl: round-robin line bus between N_HARTS harts and one backing memory, with an AMO lock.
// Define BUS_INV_EN to broadcast an invalidate to the other harts after every write.
`ifndef HMEM_LINE
`define HMEM_LINE 512
`endif
module bus_ctrl #(
  parameter int N_HARTS = 2,
  parameter int LINE    = `HMEM_LINE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_HARTS*64-1:0]   h_addr,
  input  logic [N_HARTS-1:0]      h_rd,
  input  logic [N_HARTS-1:0]      h_wr,
  input  logic [N_HARTS*LINE-1:0] h_data_out,
  output logic [LINE-1:0]         h_data_in,
  output logic [N_HARTS-1:0]      h_dv,
  output logic [63:0]             h_inv_addr,
  output logic [N_HARTS-1:0]      h_inv,
  input  logic [N_HARTS-1:0]      h_amo_req,
  output logic [N_HARTS-1:0]      h_amo_ack,
  output logic [63:0]             m_addr,
  output logic                    m_rd,
  output logic                    m_wr,
  output logic [LINE-1:0]         m_data_out,
  input  logic [LINE-1:0]         m_data_in,
  input  logic                    m_ack
);
  localparam int IW = N_HARTS > 1 ? $clog2(N_HARTS) : 1;
  typedef enum logic [1:0] {IDLE, MEM, INV, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, win_q, win_d, sel;
  logic [63:0] addr_q, addr_d, sel_addr;
  logic [LINE-1:0] wdata_q, wdata_d, rdata_q, rdata_d, sel_data;
  logic wr_q, wr_d, sel_wr, found;
  logic [N_HARTS-1:0] mask_q, mask_d, dv_q, dv_d, amo_q, amo_d, elig, win_oh;
  assign win_oh = N_HARTS'(1) << win_q;
  // scan offsets from rr so the first eligible hart at or after the pointer wins
  always_comb begin
    elig = (h_rd | h_wr) & ~mask_q;
    found = 1'b0;
    sel = rr_q;
    sel_addr = '0;
    sel_data = '0;
    sel_wr = 1'b0;
    for (int k = 0; k < N_HARTS; k++)
      for (int i = 0; i < N_HARTS; i++)
        if (!found && elig[i] && i == (int'(rr_q) + k) % N_HARTS) begin
          found = 1'b1;
          sel = IW'(i);
          sel_addr = h_addr[i*64 +: 64];
          sel_data = h_data_out[i*LINE +: LINE];
          sel_wr = h_wr[i];
        end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    win_d = win_q;
    addr_d = addr_q;
    wr_d = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mask_d = '0;
    case (state_q)
      IDLE: if (found) begin
        win_d = sel;
        addr_d = sel_addr;
        wr_d = sel_wr;
        wdata_d = sel_data;
        state_d = MEM;
      end
      MEM: if (m_ack) begin
        rdata_d = wr_q ? rdata_q : m_data_in;
`ifdef BUS_INV_EN
        state_d = wr_q ? INV : RESP;
`else
        state_d = RESP;
`endif
      end
      INV: state_d = RESP;
      RESP: begin
        rr_d = (int'(win_q) == N_HARTS - 1) ? '0 : win_q + 1'b1;
        mask_d = win_oh;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dv_d = (state_d == RESP) ? win_oh : '0;
    amo_d = (amo_q == '0) ? (h_amo_req & (~h_amo_req + N_HARTS'(1))) :
            ((amo_q & h_amo_req) != '0) ? amo_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= '0;
      win_q <= '0;
      addr_q <= '0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      mask_q <= '0;
      dv_q <= '0;
      amo_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      win_q <= win_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mask_q <= mask_d;
      dv_q <= dv_d;
      amo_q <= amo_d;
    end
`ifdef BUS_INV_EN
  logic [N_HARTS-1:0] inv_q;
  logic [63:0] inv_addr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inv_q <= '0;
      inv_addr_q <= '0;
    end else begin
      inv_q <= (state_d == INV) ? ~win_oh : '0;
      inv_addr_q <= (state_d == INV) ? addr_q : inv_addr_q;
    end
  assign h_inv = inv_q;
  assign h_inv_addr = inv_addr_q;
`else
  assign h_inv = '0;
  assign h_inv_addr = '0;
`endif
  assign h_dv = dv_q;
  assign h_data_in = rdata_q;
  assign h_amo_ack = amo_q;
  assign m_rd = (state_q == MEM) && !wr_q;
  assign m_wr = (state_q == MEM) && wr_q;
  assign m_addr = (state_q == MEM) ? addr_q : '0;
  assign m_data_out = m_wr ? wdata_q : '0;
endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: scoreboard bench for bus_ctrl with a latency-programmable memory model.
module tb_bus_ctrl;
  localparam int N = 2;
  localparam int L = 64;
`ifdef BUS_INV_EN
  localparam int WLAT = 2;
  localparam bit INV_EN = 1'b1;
`else
  localparam int WLAT = 1;
  localparam bit INV_EN = 1'b0;
`endif
  typedef struct {
    int hart;
    bit wr;
    logic [63:0] addr;
    logic [L-1:0] wdata;
    logic [L-1:0] rdata;
  } txn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*64-1:0] h_addr = '0;
  logic [N-1:0] h_rd, h_wr;
  logic [N*L-1:0] h_data_out = '0;
  logic [L-1:0] h_data_in;
  logic [N-1:0] h_dv, h_inv, h_amo_ack;
  logic [N-1:0] h_amo_req = '0;
  logic [63:0] h_inv_addr, m_addr;
  logic m_rd, m_wr;
  logic [L-1:0] m_data_out;
  logic [L-1:0] m_data_in = '0;
  logic m_ack = 1'b0;
  txn_t mq[$], rq[$], cur;
  int req_n[N], srv_n[N];
  bit op_wr[N];
  bit both = 1'b0, ack_in_rst = 1'b0, inv_seen = 1'b0;
  int n_tests = 0, n_fail = 0, cyc = 0, ack_cyc = 0, lat = 3, cnt = 0;
  logic [L-1:0] last_rd = '0;

  bus_ctrl #(.N_HARTS(N), .LINE(L)) dut (
    .clk(clk), .rst_n(rst_n), .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr),
    .h_data_out(h_data_out), .h_data_in(h_data_in), .h_dv(h_dv),
    .h_inv_addr(h_inv_addr), .h_inv(h_inv), .h_amo_req(h_amo_req),
    .h_amo_ack(h_amo_ack), .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr),
    .m_data_out(m_data_out), .m_data_in(m_data_in), .m_ack(m_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [L-1:0] mdata(input logic [63:0] a);
    return (a == 64'h1000) ? {8{8'hA5}} : {a[31:0], ~a[31:0]};
  endfunction

  // each hart holds its request until it has seen as many h_dv pulses as it issued
  always_comb begin
    h_rd = '0;
    h_wr = '0;
    for (int i = 0; i < N; i++) begin
      h_rd[i] = (req_n[i] != srv_n[i]) && (!op_wr[i] || both);
      h_wr[i] = (req_n[i] != srv_n[i]) && op_wr[i];
    end
  end

  task automatic issue(input int h, input bit wr, input logic [63:0] a, input logic [L-1:0] d);
    txn_t t;
    t.hart = h;
    t.wr = wr;
    t.addr = a;
    t.wdata = d;
    t.rdata = wr ? last_rd : mdata(a);
    if (!wr) last_rd = t.rdata;
    mq.push_back(t);
    rq.push_back(t);
    h_addr[h*64 +: 64] = a;
    h_data_out[h*L +: L] = d;
    op_wr[h] = wr;
    req_n[h]++;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && rq.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(rq.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ack = ack_in_rst;
      cnt = 0;
    end else if ((m_rd || m_wr) && !m_ack) begin
      cnt++;
      if (cnt == 1) begin
        chk("mq_nonempty", 64'(mq.size() != 0), 64'd1);
        if (mq.size() != 0) cur = mq.pop_front();
        chk("m_wr", 64'(m_wr), 64'(cur.wr));
        chk("m_rd", 64'(m_rd), 64'(!cur.wr));
        chk("m_addr", m_addr, cur.addr);
      end
      if (cnt == lat) begin
        chk("m_addr_ack", m_addr, cur.addr);
        if (cur.wr) chk("m_wdata", m_data_out, cur.wdata);
        m_data_in = mdata(m_addr);
        m_ack = 1'b1;
        ack_cyc = cyc;
      end
    end else begin
      m_ack = 1'b0;
      cnt = 0;
    end
  end

  always @(negedge clk) if (rst_n) begin
    logic [N-1:0] oh;
    txn_t e;
    if (h_inv != '0) begin
      inv_seen = 1'b1;
      if (rq.size() != 0) begin
        oh = N'(1) << rq[0].hart;
        chk("inv_vec", 64'(h_inv), 64'(~oh));
        chk("inv_addr", h_inv_addr, rq[0].addr);
        chk("inv_lat", 64'(cyc - ack_cyc), 64'd1);
      end
    end
    if (h_dv != '0) begin
      chk("dv_onehot", 64'($countones(h_dv)), 64'd1);
      chk("rq_nonempty", 64'(rq.size() != 0), 64'd1);
      if (rq.size() != 0) begin
        e = rq.pop_front();
        oh = N'(1) << e.hart;
        chk("dv_hart", 64'(h_dv), 64'(oh));
        chk("rdata", h_data_in, e.rdata);
        chk("dv_lat", 64'(cyc - ack_cyc), e.wr ? 64'(WLAT) : 64'd1);
        chk("inv_seen", 64'(inv_seen), 64'(e.wr && INV_EN));
        if (!INV_EN) chk("inv_addr0", h_inv_addr, 64'd0);
      end
      inv_seen = 1'b0;
      for (int i = 0; i < N; i++) if (h_dv[i]) srv_n[i]++;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_dv"}, 64'(h_dv), 64'd0);
    chk({tag, "_inv"}, 64'(h_inv), 64'd0);
    chk({tag, "_amo"}, 64'(h_amo_ack), 64'd0);
    chk({tag, "_mrw"}, 64'({m_rd, m_wr}), 64'd0);
    chk({tag, "_maddr"}, m_addr, 64'd0);
    chk({tag, "_mdo"}, m_data_out, 64'd0);
    chk({tag, "_hdi"}, h_data_in, 64'd0);
    chk({tag, "_iaddr"}, h_inv_addr, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      req_n[i] = 0;
      srv_n[i] = 0;
      op_wr[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // hart 0 read of 0x1000, memory acks on the third strobe cycle
    lat = 3;
    issue(0, 1'b0, 64'h1000, '0);
    wait_done();
    // hart 1 write; its address/data change after latching must not leak out
    issue(1, 1'b1, 64'h2040, 64'hDEAD_BEEF_0123_4567);
    repeat (2) @(negedge clk);
    h_addr[64 +: 64] = 64'hFFFF_0000;
    h_data_out[L +: L] = '0;
    wait_done();
    // both harts read back-to-back from rr=0: grants 0,1,0,1
    lat = 1;
    issue(0, 1'b0, 64'h100, '0);
    issue(1, 1'b0, 64'h200, '0);
    issue(0, 1'b0, 64'h100, '0);
    issue(1, 1'b0, 64'h200, '0);
    wait_done();
    // rd and wr together on one hart: the write wins
    lat = 2;
    both = 1'b1;
    issue(0, 1'b1, 64'h3000, 64'h1111_2222_3333_4444);
    wait_done();
    both = 1'b0;
    // simultaneous requests with rr=1: hart 1 first, hart 0 waits without loss
    issue(1, 1'b0, 64'h4400, '0);
    issue(0, 1'b1, 64'h4000, 64'h5555_6666_7777_8888);
    wait_done();
    // reset in the middle of a memory access, with m_ack raised during reset
    lat = 20;
    issue(1, 1'b0, 64'h5000, '0);
    for (int i = 0; i < 20 && !m_rd; i++) @(negedge clk);
    chk("abort_mrd", 64'(m_rd), 64'd1);
    repeat (2) @(negedge clk);
    ack_in_rst = 1'b1;
    rst_n = 1'b0;
    req_n[1]--;
    void'(rq.pop_front());
    last_rd = '0;
    #1 chk_zero("abort");
    repeat (2) @(negedge clk);
    chk("abort_ack", 64'(m_ack), 64'd1);
    chk_zero("abort2");
    ack_in_rst = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_dv", 64'(h_dv), 64'd0);
    chk("post_rst_mrd", 64'(m_rd), 64'd0);
    lat = 2;
    issue(0, 1'b0, 64'h6000, '0);
    wait_done();
    // AMO lock arbitration while a hart 1 read proceeds alongside
    h_amo_req = 2'b11;
    issue(1, 1'b0, 64'h7000, '0);
    @(negedge clk) chk("amo_grant", 64'(h_amo_ack), 64'h1);
    @(negedge clk) chk("amo_hold", 64'(h_amo_ack), 64'h1);
    h_amo_req = 2'b10;
    @(negedge clk) chk("amo_drop", 64'(h_amo_ack), 64'h0);
    @(negedge clk) chk("amo_next", 64'(h_amo_ack), 64'h2);
    h_amo_req = 2'b11;
    @(negedge clk) chk("amo_keep", 64'(h_amo_ack), 64'h2);
    h_amo_req = 2'b00;
    @(negedge clk) chk("amo_free", 64'(h_amo_ack), 64'h0);
    wait_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
